fpu_addsub_arbiter: RTL and testbench

Shares one `FPU_Add_Subtract_Function` instance between two requesters, such as the range-reduction and series-evaluation stages of the natural-logarithm datapath. It grants requests round-robin and latches the granted operands. It then sequences the unit's `rst_FSM`/`beg_FSM` protocol, waits for `ready` under a watchdog, and returns the result on a single tagged response channel.

---
 rtl/fpu_addsub_arbiter.sv | 143 ++++++++++++++
 tb/tb_fpu_addsub_arbiter.sv | 394 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_addsub_arbiter.sv
// Round-robin arbiter sharing one FPU add/subtract unit between two requesters.
// Sequences the unit's rst_FSM/beg_FSM handshake, waits for ready under a watchdog, returns a tagged response.
module fpu_addsub_arbiter #(
    parameter int unsigned W       = 32,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [2*W-1:0]   req_x,
    input  logic [2*W-1:0]   req_y,
    input  logic [1:0]       req_op,
    input  logic [3:0]       req_rmode,
    output logic [W-1:0]     fpu_data_x,
    output logic [W-1:0]     fpu_data_y,
    output logic             fpu_add_subt,
    output logic [1:0]       fpu_r_mode,
    output logic             fpu_beg,
    output logic             fpu_rst_fsm,
    input  logic             fpu_ready,
    input  logic [W-1:0]     fpu_result,
    input  logic             fpu_ovf,
    input  logic             fpu_unf,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             resp_id,
    output logic [W-1:0]     resp_result,
    output logic             resp_ovf,
    output logic             resp_unf,
    output logic             resp_timeout
);

    localparam int unsigned   CW       = $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CLEAR  = 3'd1;
    localparam logic [2:0] S_LAUNCH = 3'd2;
    localparam logic [2:0] S_WAIT   = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    logic [2:0]    state;
    logic [2:0]    state_nx;
    logic          prio;
    logic [CW-1:0] cnt;
    logic          id_r;
    logic [1:0]    grant_c;
    logic          gsel;
    logic          wait_expire;

    // Winner among valid requesters; prio only matters when both are valid
    always_comb begin
        grant_c = 2'b00;
        if (state == S_IDLE && !rst) begin
            case (req_valid)
                2'b01:   grant_c = 2'b01;
                2'b10:   grant_c = 2'b10;
                2'b11:   grant_c = prio ? 2'b10 : 2'b01;
                default: grant_c = 2'b00;
            endcase
        end
    end

    assign req_ready   = grant_c;
    assign gsel        = grant_c[1];
    assign wait_expire = (cnt == CNT_LAST);

    // Moore decodes of the state register
    assign fpu_rst_fsm = (state == S_CLEAR);
    assign fpu_beg     = (state == S_LAUNCH);
    assign resp_valid  = (state == S_DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:   if (grant_c != 2'b00) state_nx = S_CLEAR;
            S_CLEAR:  state_nx = S_LAUNCH;
            S_LAUNCH: state_nx = S_WAIT;
            S_WAIT:   if (fpu_ready || wait_expire) state_nx = S_DONE;
            S_DONE:   if (resp_ready) state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    // Operand latch, watchdog counter and response capture
    always_ff @(posedge clk) begin
        if (rst) begin
            prio         <= 1'b0;
            cnt          <= '0;
            id_r         <= 1'b0;
            fpu_data_x   <= '0;
            fpu_data_y   <= '0;
            fpu_add_subt <= 1'b0;
            fpu_r_mode   <= 2'b00;
            resp_id      <= 1'b0;
            resp_result  <= '0;
            resp_ovf     <= 1'b0;
            resp_unf     <= 1'b0;
            resp_timeout <= 1'b0;
        end else begin
            if (state == S_IDLE && grant_c != 2'b00) begin
                fpu_data_x   <= gsel ? req_x[2*W-1:W] : req_x[W-1:0];
                fpu_data_y   <= gsel ? req_y[2*W-1:W] : req_y[W-1:0];
                fpu_add_subt <= gsel ? req_op[1] : req_op[0];
                fpu_r_mode   <= gsel ? req_rmode[3:2] : req_rmode[1:0];
                id_r         <= gsel;
                prio         <= ~gsel;
            end

            if (state == S_LAUNCH) begin
                cnt <= '0;
            end else if (state == S_WAIT && !fpu_ready && !wait_expire) begin
                cnt <= cnt + CW'(1);
            end

            if (state == S_WAIT) begin
                if (fpu_ready) begin
                    resp_id      <= id_r;
                    resp_result  <= fpu_result;
                    resp_ovf     <= fpu_ovf;
                    resp_unf     <= fpu_unf;
                    resp_timeout <= 1'b0;
                end else if (wait_expire) begin
                    resp_id      <= id_r;
                    resp_result  <= '0;
                    resp_ovf     <= 1'b0;
                    resp_unf     <= 1'b0;
                    resp_timeout <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_fpu_addsub_arbiter.sv
// Bench for fpu_addsub_arbiter: FPU stub, transaction-level reference model with a per-cycle compare,
// directed scenarios with hand-computed expectations, then a randomized phase.
module tb_fpu_addsub_arbiter;

    localparam int unsigned W       = 32;
    localparam int unsigned TIMEOUT = 64;

    logic           clk;
    logic           rst;
    logic [1:0]     req_valid;
    logic [1:0]     req_ready;
    logic [2*W-1:0] req_x;
    logic [2*W-1:0] req_y;
    logic [1:0]     req_op;
    logic [3:0]     req_rmode;
    logic [W-1:0]   fpu_data_x;
    logic [W-1:0]   fpu_data_y;
    logic           fpu_add_subt;
    logic [1:0]     fpu_r_mode;
    logic           fpu_beg;
    logic           fpu_rst_fsm;
    logic           fpu_ready;
    logic [W-1:0]   fpu_result;
    logic           fpu_ovf;
    logic           fpu_unf;
    logic           resp_valid;
    logic           resp_ready;
    logic           resp_id;
    logic [W-1:0]   resp_result;
    logic           resp_ovf;
    logic           resp_unf;
    logic           resp_timeout;

    fpu_addsub_arbiter #(.W(W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_x(req_x), .req_y(req_y), .req_op(req_op), .req_rmode(req_rmode),
        .fpu_data_x(fpu_data_x), .fpu_data_y(fpu_data_y),
        .fpu_add_subt(fpu_add_subt), .fpu_r_mode(fpu_r_mode),
        .fpu_beg(fpu_beg), .fpu_rst_fsm(fpu_rst_fsm),
        .fpu_ready(fpu_ready), .fpu_result(fpu_result),
        .fpu_ovf(fpu_ovf), .fpu_unf(fpu_unf),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_result(resp_result), .resp_ovf(resp_ovf), .resp_unf(resp_unf),
        .resp_timeout(resp_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Single-precision add/subtract via doubles (normal operands only)
    function automatic real f2r(input logic [31:0] b);
        logic [63:0] d;
        logic [10:0] e;
        if (b[30:23] == 8'd0) return 0.0;
        e = 11'(b[30:23]) + 11'd896;
        d = {b[31], e, b[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] d;
        logic [10:0] e;
        logic [7:0]  ef;
        d = $realtobits(r);
        if (d[62:0] == 63'd0) return 32'd0;
        e  = d[62:52];
        ef = 8'(e - 11'd896);
        return {d[63], ef, d[51:29]};
    endfunction

    function automatic logic [31:0] fp_addsub(input logic [31:0] x, input logic [31:0] y, input logic op);
        real a, b;
        a = f2r(x);
        b = f2r(y);
        return r2f(op ? a - b : a + b);
    endfunction

    function automatic logic [31:0] rand_fp();
        logic [31:0] v;
        v = $urandom;
        v[30:23] = 8'($urandom_range(120, 134));
        return v;
    endfunction

    // FPU stub: ready rises 'delay' WAIT cycles after beg, stays high (stale) until rst_FSM
    int          s_delay;
    int          s_age;
    logic        s_active;
    logic        s_ovf, s_unf, s_ovf_r, s_unf_r;
    logic [31:0] s_res, s_junk;

    always @(posedge clk) begin
        s_junk <= $urandom;
        if (rst || fpu_rst_fsm) begin
            s_active  <= 1'b0;
            fpu_ready <= 1'b0;
        end else if (fpu_beg) begin
            s_active  <= 1'b1;
            s_age     <= 0;
            fpu_ready <= (s_delay == 0);
            s_res     <= fp_addsub(fpu_data_x, fpu_data_y, fpu_add_subt);
            s_ovf_r   <= s_ovf;
            s_unf_r   <= s_unf;
        end else if (s_active) begin
            s_age     <= s_age + 1;
            fpu_ready <= (s_age + 1 >= s_delay);
        end
    end

    assign fpu_result = fpu_ready ? s_res : s_junk;
    assign fpu_ovf    = fpu_ready ? s_ovf_r : s_junk[0];
    assign fpu_unf    = fpu_ready ? s_unf_r : s_junk[1];

    function automatic logic [107:0] dut_vec();
        return {req_ready, fpu_data_x, fpu_data_y, fpu_add_subt, fpu_r_mode, fpu_beg, fpu_rst_fsm,
                resp_valid, resp_id, resp_result, resp_ovf, resp_unf, resp_timeout};
    endfunction

    function automatic logic [1:0] winner(input logic [1:0] v, input logic p);
        if (v == 2'b11) return p ? 2'b10 : 2'b01;
        return v;
    endfunction

    // Reference model: one transaction in flight, t = cycles since the grant cycle
    bit          started = 0;
    bit          busy    = 0;
    bit          force_to = 0;
    bit          rand_phase = 0;
    int          t, done_t, d;
    logic        prio_m;
    logic [31:0] m_x, m_y;
    logic        m_op;
    logic [1:0]  m_rm;
    logic        e_id, e_ovf, e_unf, e_to;
    logic [31:0] e_res;
    logic        h_id, h_ovf, h_unf, h_to;
    logic [31:0] h_res;
    logic [1:0]  hs_last;

    always @(negedge clk) begin
        logic [1:0]   exp_rdy;
        logic [107:0] ev;
        logic         g;
        hs_last = 2'b00;
        if (rst) begin
            started = 1;
            busy    = 0;
            prio_m  = 1'b0;
            m_x = '0; m_y = '0; m_op = 1'b0; m_rm = 2'b00;
            h_id = 1'b0; h_res = '0; h_ovf = 1'b0; h_unf = 1'b0; h_to = 1'b0;
        end else if (started) begin
            if (busy) t++;
            if (busy && t == done_t) begin
                h_id = e_id; h_res = e_res; h_ovf = e_ovf; h_unf = e_unf; h_to = e_to;
            end
            exp_rdy = busy ? 2'b00 : winner(req_valid, prio_m);
            ev = {exp_rdy, m_x, m_y, m_op, m_rm, busy && t == 2, busy && t == 1,
                  busy && t >= done_t, h_id, h_res, h_ovf, h_unf, h_to};
            chk("cycle_model", 128'(dut_vec()), 128'(ev));
            hs_last = req_valid & req_ready;
            if (busy) begin
                if (t >= done_t && resp_ready) busy = 0;
            end else if (exp_rdy != 2'b00 && (req_valid & exp_rdy) != 2'b00) begin
                g      = exp_rdy[1];
                busy   = 1;
                t      = 0;
                e_id   = g;
                m_x    = g ? req_x[63:32] : req_x[31:0];
                m_y    = g ? req_y[63:32] : req_y[31:0];
                m_op   = req_op[g];
                m_rm   = g ? req_rmode[3:2] : req_rmode[1:0];
                prio_m = ~g;
                if (force_to) d = 1000;
                else if (rand_phase) d = ($urandom_range(0, 99) < 3) ? int'($urandom_range(TIMEOUT, TIMEOUT + 10))
                                                                     : int'($urandom_range(0, 6));
                else d = int'($urandom_range(0, 3));
                s_delay = d;
                s_ovf   = rand_phase ? 1'($urandom) : 1'b0;
                s_unf   = rand_phase ? 1'($urandom) : 1'b0;
                if (d <= int'(TIMEOUT) - 1) begin
                    done_t = 4 + d;
                    e_res = fp_addsub(m_x, m_y, m_op); e_ovf = s_ovf; e_unf = s_unf; e_to = 1'b0;
                end else begin
                    done_t = 4 + int'(TIMEOUT) - 1;
                    e_res = '0; e_ovf = 1'b0; e_unf = 1'b0; e_to = 1'b1;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [31:0] x, input logic [31:0] y,
                           input logic op, input logic [1:0] rm);
        req_x[i*W +: W]   = x;
        req_y[i*W +: W]   = y;
        req_op[i]         = op;
        req_rmode[i*2 +: 2] = rm;
    endtask

    // Returns one cycle after the handshake edge (CLEAR state)
    task automatic do_op(input int i, input logic [31:0] x, input logic [31:0] y,
                         input logic op, input logic [1:0] rm);
        int n;
        set_req(i, x, y, op, rm);
        req_valid[i] = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (!hs_last[i] && n < 200);
        req_valid[i] = 1'b0;
        chk("grant_seen", 128'(hs_last[i]), 128'(1));
    endtask

    task automatic wait_resp();
        int n;
        n = 0;
        while (!resp_valid && n < 300) begin
            tick();
            n++;
        end
        chk("resp_seen", 128'(resp_valid), 128'(1));
    endtask

    task automatic accept();
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int          n, cnt;
        bit          seen;
        logic        order [4];
        logic [35:0] snap;

        rst = 1'b1; req_valid = 2'b00; req_x = '0; req_y = '0; req_op = 2'b00; req_rmode = 4'b0000;
        resp_ready = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        #1;
        chk("reset_outputs", 128'(dut_vec()), 128'(0));

        // Single add from requester 0
        do_op(0, 32'h40066666, 32'h40466666, 1'b0, 2'b01);
        chk("clear_pulse", 128'({fpu_rst_fsm, fpu_beg}), 128'(2'b10));
        tick();
        chk("launch_pulse", 128'({fpu_rst_fsm, fpu_beg}), 128'(2'b01));
        wait_resp();
        chk("add_resp", 128'({resp_id, resp_result, resp_ovf, resp_unf, resp_timeout}),
            128'({1'b0, 32'h40A66666, 3'b000}));
        accept();

        // Single subtract from requester 1
        do_op(1, 32'h40466666, 32'h40066666, 1'b1, 2'b00);
        wait_resp();
        chk("sub_resp", 128'({resp_id, resp_result, resp_timeout}), 128'({1'b1, 32'h3F800000, 1'b0}));
        accept();

        // Contention from reset: grants alternate 0,1,0,1
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_req(0, rand_fp(), rand_fp(), 1'b0, 2'b10);
        set_req(1, rand_fp(), rand_fp(), 1'b1, 2'b11);
        req_valid = 2'b11; resp_ready = 1'b1;
        cnt = 0; n = 0;
        while (cnt < 4 && n < 400) begin
            tick();
            n++;
            if (hs_last != 2'b00) begin
                order[cnt] = hs_last[1];
                cnt++;
            end
        end
        req_valid = 2'b00;
        chk("contention_count", 128'(cnt), 128'(4));
        chk("contention_g0", 128'(order[0]), 128'(0));
        chk("contention_g1", 128'(order[1]), 128'(1));
        chk("contention_g2", 128'(order[2]), 128'(0));
        chk("contention_g3", 128'(order[3]), 128'(1));
        repeat (20) tick();
        resp_ready = 1'b0;

        // Watchdog expiry, then a normal operation
        force_to = 1;
        do_op(0, rand_fp(), rand_fp(), 1'b0, 2'b00);
        tick();
        chk("watchdog_beg", 128'(fpu_beg), 128'(1));
        n = 0;
        while (!resp_valid && n < 200) begin
            tick();
            n++;
        end
        chk("watchdog_latency", 128'(n), 128'(TIMEOUT + 1));
        chk("watchdog_resp", 128'({resp_timeout, resp_result, resp_ovf, resp_unf}), 128'({1'b1, 32'h0, 2'b00}));
        accept();
        force_to = 0;
        do_op(1, 32'h40066666, 32'h40466666, 1'b0, 2'b00);
        wait_resp();
        chk("post_watchdog", 128'({resp_timeout, resp_id, resp_result}), 128'({1'b0, 1'b1, 32'h40A66666}));
        accept();

        // Backpressure in DONE with requester 1 waiting
        do_op(0, rand_fp(), rand_fp(), 1'b1, 2'b01);
        set_req(1, rand_fp(), rand_fp(), 1'b0, 2'b10);
        req_valid = 2'b10;
        wait_resp();
        snap = {resp_id, resp_result, resp_ovf, resp_unf, resp_timeout};
        repeat (10) begin
            chk("stall_hold", 128'({req_ready, resp_valid, resp_id, resp_result, resp_ovf, resp_unf, resp_timeout}),
                128'({2'b00, 1'b1, snap}));
            tick();
        end
        accept();
        #1;
        chk("grant_after_accept", 128'(req_ready), 128'(2'b10));
        tick();
        chk("bp_handshake", 128'(hs_last), 128'(2'b10));
        req_valid = 2'b00;
        wait_resp();
        accept();

        // Reset during WAIT discards the operation and restores prio
        force_to = 1;
        do_op(1, rand_fp(), rand_fp(), 1'b0, 2'b00);
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        force_to = 0;
        #1;
        chk("reset_mid_wait", 128'(dut_vec()), 128'(0));
        seen = 0;
        repeat (70) begin
            tick();
            if (resp_valid) seen = 1;
        end
        chk("no_resp_after_reset", 128'(seen), 128'(0));
        set_req(0, rand_fp(), rand_fp(), 1'b0, 2'b00);
        set_req(1, rand_fp(), rand_fp(), 1'b1, 2'b01);
        req_valid = 2'b11;
        #1;
        chk("prio_after_reset", 128'(req_ready), 128'(2'b01));
        resp_ready = 1'b1;
        repeat (30) tick();
        req_valid = 2'b00;
        repeat (20) tick();

        // Randomized traffic with random backpressure and rare resets
        rand_phase = 1;
        repeat (4000) begin
            tick();
            for (int i = 0; i < 2; i++) begin
                if (hs_last[i] || !req_valid[i]) begin
                    req_valid[i] = ($urandom_range(0, 99) < 40);
                    set_req(i, rand_fp(), rand_fp(), 1'($urandom), 2'($urandom));
                end else if ($urandom_range(0, 7) == 0) begin
                    set_req(i, rand_fp(), rand_fp(), 1'($urandom), 2'($urandom));
                end
            end
            resp_ready = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 999) == 0);
        end
        rst = 1'b0; req_valid = 2'b00; resp_ready = 1'b1; rand_phase = 0;
        repeat (200) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
